pcpi_hub: RTL and testbench
===========================

# pcpi_hub

Router between the core's PCPI port and up to NUM_CP co-processors (multiplier, divider, ...). It registers and broadcasts each PCPI request, holds operands stable for the whole operation, and records which co-processor claims the instruction. It returns that co-processor's result to the core as a single registered pulse and flags instructions no co-processor claims within TIMEOUT cycles.

## Interface
- NUM_CP, 2: number of attached co-processors, 1..8.
- TIMEOUT, 16: cycles after issue without any claim before the instruction is declared unclaimed, 2..255.
- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- core_valid  in  1  core requests a PCPI operation.
- core_insn / core_rs1 / core_rs2  in  32 each  instruction word and operands.
- core_wr  out  1  result is to be written to rd; valid with core_ready.
- core_rd  out  32  result data.
- core_wait  out  1  an owner has claimed the instruction and is busy.
- core_ready  out  1  one-cycle completion pulse.
- core_unclaimed  out  1  one-cycle pulse on timeout.
- cp_conflict  out  1  sticky: more than one co-processor claimed in the same cycle.
- cp_valid  out  NUM_CP  per-co-processor valid.
- cp_insn / cp_rs1 / cp_rs2  out  32 each  registered copies broadcast to all co-processors.
- cp_wr / cp_wait / cp_ready  in  NUM_CP each  per-co-processor response flags.
- cp_rd  in  32*NUM_CP  results; co-processor k uses bits [32k+31:32k].

## Operation
- FSM states: IDLE, ISSUE, BUSY, DRAIN, ABORT.
- IDLE: on core_valid, latch insn/rs1/rs2 into cp_* registers, set all cp_valid bits, load the timeout counter with TIMEOUT, and go to ISSUE.
- ISSUE: claim = any cp_wait or cp_ready. The lowest claiming index becomes owner. If more than one bit is set, set cp_conflict.
  - Claim via cp_ready only (single-cycle co-processor) completes immediately: response, then DRAIN.
  - Claim via cp_wait goes to BUSY.
  - No claim: decrement the counter. When the counter reaches 0, pulse core_unclaimed, clear cp_valid, go to DRAIN.
- BUSY: core_wait=1. On cp_ready[owner], capture cp_rd[owner] and cp_wr[owner], pulse core_ready, clear cp_valid, go to DRAIN. cp_ready from non-owners is ignored.
- DRAIN: wait for core_valid=0, then go to IDLE. No new issue from DRAIN.
- Abort: core_valid=0 while in ISSUE or BUSY clears cp_valid and goes to ABORT. ABORT stays until all cp_wait bits are 0, then goes to IDLE. Any late cp_ready is dropped: no core_ready pulse.
- Operands and cp_insn are held constant from issue until cp_valid clears.
- core_rd holds its last value between completions. core_wr is 0 whenever core_ready is 0.

## Timing
- Reset (asynchronous, resetn low): state IDLE; counter 0; cp_valid, core_wr, core_wait, core_ready, core_unclaimed, cp_conflict all 0; core_rd, cp_insn, cp_rs1, cp_rs2 all 0.
- core_valid sampled at cycle 0: cp_valid and operands are visible at cycle 1.
- Claim sampled at cycle n: core_wait is high from n+1.
- cp_ready[owner] sampled at cycle m: core_ready, core_wr, core_rd are valid at m+1 for exactly one cycle, and core_wait drops at m+1.
- With the current multiplier, a MUL issued at cycle 0 claims at cycle 3.
- Timeout: with no claim, core_unclaimed pulses exactly TIMEOUT+1 cycles after cp_valid rises.
- Claim and counter reaching 0 in the same cycle: the claim wins.
- cp_ready and core_valid falling in the same cycle (BUSY): the abort wins, and no response is sent.

## Structure
- Package pcpi_pkg: state enum, PCPI opcode/funct7 constants, 32-bit data width constant.
- Sub-module pcpi_resp_sel: priority encoder (owner index, conflict flag) plus the cp_rd/cp_wr owner mux.

## Test plan
- MUL rs1=7, rs2=6 with multiplier at port 0 -> core_wait high from cycle 4, single core_ready with core_wr=1, core_rd=42; cp_rs1/cp_rs2 stable throughout.
- Unknown insn 0x0000000B, TIMEOUT=16 -> core_unclaimed pulse 17 cycles after cp_valid rises; core_ready never asserted; FSM back in IDLE after core_valid drops.
- Ports 0 and 1 both assert cp_wait in the same cycle -> owner=0, cp_conflict=1 and stays set; cp_ready[1] with rd=0xDEAD is ignored; cp_ready[0] with rd=5 gives core_rd=5.
- core_valid dropped mid-BUSY of MULHU -> cp_valid clears next cycle; late cp_ready produces no core_ready; a new request is accepted only after cp_wait=0.
- resetn asserted during BUSY -> all outputs 0 immediately without a clock edge; after release, MUL 0xFFFFFFFF*2 returns 0xFFFFFFFE.
- Single-cycle co-processor returns cp_ready (no wait) at cycle 2 -> core_ready at cycle 3; core_wait never asserted.

Source files
------------

// File: rtl/pcpi_pkg.sv
// rtl/pcpi_pkg.sv - shared types and constants for the PCPI hub
// Contents: hub FSM state enum, RV32M opcode/funct constants, data width,
// and an instruction-builder helper for R-type MUL/DIV words.
package pcpi_pkg;

    localparam int DATA_W = 32;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_BUSY,
        ST_DRAIN,
        ST_ABORT
    } hub_state_t;

    function automatic logic [31:0] muldiv_insn(input logic [2:0] f3,
                                                input logic [4:0] rd,
                                                input logic [4:0] rs1,
                                                input logic [4:0] rs2);
        return {FUNCT7_MULDIV, rs2, rs1, f3, rd, OPCODE_OP};
    endfunction

endpackage

// File: rtl/pcpi_hub_if.sv
// rtl/pcpi_hub_if.sv - PCPI core-side and co-processor-side signal bundle
// Core side: core_valid/core_insn/core_rs1/core_rs2 in; core_wr/core_rd/
// core_wait/core_ready/core_unclaimed out. Co-processor side: cp_valid/cp_insn/
// cp_rs1/cp_rs2 out; cp_wr/cp_wait/cp_ready/cp_rd in. cp_conflict is a status out.
// Modport slave is the hub's view; master is the surrounding core/co-processors.
interface pcpi_hub_if #(
    parameter int NUM_CP = 2
);
    import pcpi_pkg::*;

    logic                     core_valid;
    logic [DATA_W-1:0]        core_insn;
    logic [DATA_W-1:0]        core_rs1;
    logic [DATA_W-1:0]        core_rs2;
    logic                     core_wr;
    logic [DATA_W-1:0]        core_rd;
    logic                     core_wait;
    logic                     core_ready;
    logic                     core_unclaimed;
    logic                     cp_conflict;

    logic [NUM_CP-1:0]        cp_valid;
    logic [DATA_W-1:0]        cp_insn;
    logic [DATA_W-1:0]        cp_rs1;
    logic [DATA_W-1:0]        cp_rs2;
    logic [NUM_CP-1:0]        cp_wr;
    logic [NUM_CP-1:0]        cp_wait;
    logic [NUM_CP-1:0]        cp_ready;
    logic [NUM_CP*DATA_W-1:0] cp_rd;

    modport slave (
        input  core_valid, core_insn, core_rs1, core_rs2,
        output core_wr, core_rd, core_wait, core_ready, core_unclaimed, cp_conflict,
        output cp_valid, cp_insn, cp_rs1, cp_rs2,
        input  cp_wr, cp_wait, cp_ready, cp_rd
    );

    modport master (
        output core_valid, core_insn, core_rs1, core_rs2,
        input  core_wr, core_rd, core_wait, core_ready, core_unclaimed, cp_conflict,
        input  cp_valid, cp_insn, cp_rs1, cp_rs2,
        output cp_wr, cp_wait, cp_ready, cp_rd
    );

endinterface

// File: rtl/pcpi_resp_sel.sv
// rtl/pcpi_resp_sel.sv - claim priority encoder and owner response mux
// Inputs: claim vector, per-port cp_wr/cp_ready/cp_rd, registered owner and
// use_enc (pick the fresh encoder result instead of the registered owner).
// Outputs: any_claim, multi_claim, enc_idx (lowest claiming port), and the
// selected port's ready/wr/rd.
module pcpi_resp_sel
    import pcpi_pkg::*;
#(
    parameter int NUM_CP = 2,
    parameter int IDX_W  = (NUM_CP > 1) ? $clog2(NUM_CP) : 1
) (
    input  logic [NUM_CP-1:0]        claim,
    input  logic [NUM_CP-1:0]        cp_wr,
    input  logic [NUM_CP-1:0]        cp_ready,
    input  logic [NUM_CP*DATA_W-1:0] cp_rd,
    input  logic                     use_enc,
    input  logic [IDX_W-1:0]         owner_q,
    output logic                     any_claim,
    output logic                     multi_claim,
    output logic [IDX_W-1:0]         enc_idx,
    output logic                     sel_ready,
    output logic                     sel_wr,
    output logic [DATA_W-1:0]        sel_rd
);

    logic [IDX_W-1:0] sel;

    // Scan from the top down so the lowest set index is the last write.
    always_comb begin
        enc_idx = '0;
        for (int k = NUM_CP - 1; k >= 0; k--) begin
            if (claim[k]) begin
                enc_idx = IDX_W'(k);
            end
        end
    end

    assign any_claim   = |claim;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_claim = (claim & (claim - NUM_CP'(1))) != '0;

    assign sel       = use_enc ? enc_idx : owner_q;
    assign sel_ready = cp_ready[sel];
    assign sel_wr    = cp_wr[sel];
    assign sel_rd    = cp_rd[sel*DATA_W +: DATA_W];

endmodule

// File: rtl/pcpi_hub.sv
// rtl/pcpi_hub.sv - PCPI router between the core and NUM_CP co-processors
// Ports: clk, resetn (async, active low), bus (pcpi_hub_if.slave).
// Registers each core request onto the broadcast cp_* lines, tracks which
// co-processor owns it, returns the owner's result as a one-cycle core_ready
// pulse, and pulses core_unclaimed when nobody claims within TIMEOUT cycles.
module pcpi_hub
    import pcpi_pkg::*;
#(
    parameter int NUM_CP  = 2,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         resetn,
    pcpi_hub_if.slave    bus
);

    localparam int IDX_W = (NUM_CP > 1) ? $clog2(NUM_CP) : 1;

    hub_state_t          state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [NUM_CP-1:0]   cp_valid_q, cp_valid_d;
    logic [DATA_W-1:0]   insn_q, insn_d;
    logic [DATA_W-1:0]   rs1_q, rs1_d;
    logic [DATA_W-1:0]   rs2_q, rs2_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [DATA_W-1:0]   rd_q, rd_d;
    logic                wr_q, wr_d;
    logic                ready_q, ready_d;
    logic                unclaimed_q, unclaimed_d;
    logic                conflict_q, conflict_d;

    logic                any_claim, multi_claim, sel_ready, sel_wr;
    logic [IDX_W-1:0]    enc_idx;
    logic [DATA_W-1:0]   sel_rd;

    pcpi_resp_sel #(
        .NUM_CP (NUM_CP),
        .IDX_W  (IDX_W)
    ) u_resp_sel (
        .claim       (bus.cp_wait | bus.cp_ready),
        .cp_wr       (bus.cp_wr),
        .cp_ready    (bus.cp_ready),
        .cp_rd       (bus.cp_rd),
        .use_enc     (state_q == ST_ISSUE),
        .owner_q     (owner_q),
        .any_claim   (any_claim),
        .multi_claim (multi_claim),
        .enc_idx     (enc_idx),
        .sel_ready   (sel_ready),
        .sel_wr      (sel_wr),
        .sel_rd      (sel_rd)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cp_valid_q  <= '0;
            insn_q      <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            owner_q     <= '0;
            rd_q        <= '0;
            wr_q        <= 1'b0;
            ready_q     <= 1'b0;
            unclaimed_q <= 1'b0;
            conflict_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cp_valid_q  <= cp_valid_d;
            insn_q      <= insn_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            owner_q     <= owner_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            ready_q     <= ready_d;
            unclaimed_q <= unclaimed_d;
            conflict_q  <= conflict_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cp_valid_d  = cp_valid_q;
        insn_d      = insn_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        owner_d     = owner_q;
        rd_d        = rd_q;
        wr_d        = 1'b0;
        ready_d     = 1'b0;
        unclaimed_d = 1'b0;
        conflict_d  = conflict_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.core_valid) begin
                    insn_d     = bus.core_insn;
                    rs1_d      = bus.core_rs1;
                    rs2_d      = bus.core_rs2;
                    cp_valid_d = '1;
                    cnt_d      = 8'(TIMEOUT);
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Core withdrawal beats a claim or a timeout in the same cycle.
                if (!bus.core_valid) begin
                    cp_valid_d = '0;
                    state_d    = ST_ABORT;
                end else if (any_claim) begin
                    owner_d = enc_idx;
                    if (multi_claim) begin
                        conflict_d = 1'b1;
                    end
                    if (sel_ready) begin
                        rd_d       = sel_rd;
                        wr_d       = sel_wr;
                        ready_d    = 1'b1;
                        cp_valid_d = '0;
                        state_d    = ST_DRAIN;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end else if (cnt_q == 8'd0) begin
                    unclaimed_d = 1'b1;
                    cp_valid_d  = '0;
                    state_d     = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_BUSY: begin
                if (!bus.core_valid) begin
                    cp_valid_d = '0;
                    state_d    = ST_ABORT;
                end else if (sel_ready) begin
                    rd_d       = sel_rd;
                    wr_d       = sel_wr;
                    ready_d    = 1'b1;
                    cp_valid_d = '0;
                    state_d    = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!bus.core_valid) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ABORT: begin
                // Let every co-processor finish its abandoned work first.
                if (bus.cp_wait == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.core_wr        = wr_q;
    assign bus.core_rd        = rd_q;
    assign bus.core_wait      = (state_q == ST_BUSY);
    assign bus.core_ready     = ready_q;
    assign bus.core_unclaimed = unclaimed_q;
    assign bus.cp_conflict    = conflict_q;
    assign bus.cp_valid       = cp_valid_q;
    assign bus.cp_insn        = insn_q;
    assign bus.cp_rs1         = rs1_q;
    assign bus.cp_rs2         = rs2_q;

endmodule

// File: tb/tb_pcpi_hub.sv
// tb/tb_pcpi_hub.sv - directed self-checking bench for pcpi_hub
module tb_pcpi_hub;
    import pcpi_pkg::*;

    localparam int NUM_CP  = 2;
    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic        wr;
        logic [31:0] rd;
    } resp_t;

    logic  clk = 1'b0;
    logic  resetn = 1'b0;
    int    total = 0;
    int    bad = 0;
    int    ready_seen = 0;
    int    ready_mark;
    int    waited;
    resp_t exp_q[$];
    resp_t mon_e;
    logic [63:0] prod;

    always #5 clk = ~clk;

    pcpi_hub_if #(.NUM_CP(NUM_CP)) bus ();

    pcpi_hub #(
        .NUM_CP  (NUM_CP),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.core_valid = 1'b0;
        bus.cp_wait    = '0;
        bus.cp_ready   = '0;
        bus.cp_wr      = '0;
        bus.cp_rd      = '0;
    endtask

    task automatic drive_req(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
        bus.core_insn  = insn;
        bus.core_rs1   = a;
        bus.core_rs2   = b;
        bus.core_valid = 1'b1;
    endtask

    // Response scoreboard: every core_ready must match the oldest expected entry.
    always @(negedge clk) begin
        if (resetn) begin
            if (bus.core_ready) begin
                ready_seen++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("core_rd", bus.core_rd, mon_e.rd);
                    chk("core_wr", 32'(bus.core_wr), 32'(mon_e.wr));
                end
            end else begin
                chk("wr_without_ready", 32'(bus.core_wr), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        bus.core_insn = '0;
        bus.core_rs1  = '0;
        bus.core_rs2  = '0;

        // Reset state
        resetn = 1'b0;
        tick();
        tick();
        chk("rst_cp_valid", 32'(bus.cp_valid), 32'd0);
        chk("rst_core_wait", 32'(bus.core_wait), 32'd0);
        chk("rst_core_ready", 32'(bus.core_ready), 32'd0);
        chk("rst_unclaimed", 32'(bus.core_unclaimed), 32'd0);
        chk("rst_conflict", 32'(bus.cp_conflict), 32'd0);
        chk("rst_core_rd", bus.core_rd, 32'd0);
        chk("rst_cp_insn", bus.cp_insn, 32'd0);
        chk("rst_cp_rs1", bus.cp_rs1, 32'd0);
        resetn = 1'b1;
        tick();

        // MUL 7*6, multiplier on port 0 claims at cycle 3
        drive_req(muldiv_insn(F3_MUL, 5'd3, 5'd1, 5'd2), 32'd7, 32'd6);
        tick();                                                   // cycle 1
        chk("mul_cp_valid", 32'(bus.cp_valid), 32'd3);
        chk("mul_cp_insn", bus.cp_insn, muldiv_insn(F3_MUL, 5'd3, 5'd1, 5'd2));
        chk("mul_rs1_c1", bus.cp_rs1, 32'd7);
        tick();                                                   // cycle 2
        chk("mul_wait_c2", 32'(bus.core_wait), 32'd0);
        tick();                                                   // cycle 3
        bus.cp_wait = 2'b01;
        chk("mul_wait_c3", 32'(bus.core_wait), 32'd0);
        tick();                                                   // cycle 4
        chk("mul_wait_c4", 32'(bus.core_wait), 32'd1);
        chk("mul_rs1_c4", bus.cp_rs1, 32'd7);
        chk("mul_rs2_c4", bus.cp_rs2, 32'd6);
        prod = 64'(bus.cp_rs1) * 64'(bus.cp_rs2);
        bus.cp_wait        = 2'b00;
        bus.cp_ready       = 2'b01;
        bus.cp_wr          = 2'b01;
        bus.cp_rd[31:0]    = prod[31:0];
        exp_q.push_back('{wr: 1'b1, rd: 32'd42});
        tick();                                                   // cycle 5
        chk("mul_ready_c5", 32'(bus.core_ready), 32'd1);
        chk("mul_wait_c5", 32'(bus.core_wait), 32'd0);
        chk("mul_valid_clr", 32'(bus.cp_valid), 32'd0);
        chk("mul_rs1_c5", bus.cp_rs1, 32'd7);
        idle_inputs();
        tick();
        chk("mul_ready_pulse", 32'(bus.core_ready), 32'd0);
        tick();

        // Unknown instruction: unclaimed after TIMEOUT+1 cycles
        ready_mark = ready_seen;
        drive_req(32'h0000_000B, 32'd1, 32'd2);
        tick();
        chk("to_cp_valid", 32'(bus.cp_valid), 32'd3);
        waited = 0;
        while (!bus.core_unclaimed && waited < 40) begin
            tick();
            waited++;
        end
        chk("to_latency", 32'(waited), 32'(TIMEOUT + 1));
        chk("to_valid_clr", 32'(bus.cp_valid), 32'd0);
        tick();
        chk("to_pulse_width", 32'(bus.core_unclaimed), 32'd0);
        chk("to_no_ready", 32'(ready_seen), 32'(ready_mark));
        idle_inputs();
        tick();
        tick();

        // Two claims in one cycle: port 0 owns, non-owner ready ignored
        drive_req(muldiv_insn(F3_DIV, 5'd4, 5'd1, 5'd2), 32'd5, 32'd1);
        tick();                                                   // cycle 1
        chk("cf_accept", 32'(bus.cp_valid), 32'd3);
        tick();                                                   // cycle 2
        bus.cp_wait = 2'b11;
        tick();                                                   // cycle 3
        chk("cf_wait", 32'(bus.core_wait), 32'd1);
        chk("cf_conflict", 32'(bus.cp_conflict), 32'd1);
        bus.cp_wait         = 2'b01;
        bus.cp_ready        = 2'b10;
        bus.cp_wr           = 2'b10;
        bus.cp_rd[63:32]    = 32'h0000_DEAD;
        tick();
        chk("cf_nonowner_ready", 32'(bus.core_ready), 32'd0);
        chk("cf_still_wait", 32'(bus.core_wait), 32'd1);
        bus.cp_wait         = 2'b00;
        bus.cp_ready        = 2'b01;
        bus.cp_wr           = 2'b01;
        bus.cp_rd[31:0]     = 32'd5;
        exp_q.push_back('{wr: 1'b1, rd: 32'd5});
        tick();
        chk("cf_owner_ready", 32'(bus.core_ready), 32'd1);
        chk("cf_rd", bus.core_rd, 32'd5);
        idle_inputs();
        tick();
        tick();
        chk("cf_sticky", 32'(bus.cp_conflict), 32'd1);

        // MULHU aborted mid-BUSY with a coincident cp_ready
        ready_mark = ready_seen;
        drive_req(muldiv_insn(F3_MULHU, 5'd6, 5'd1, 5'd2), 32'h8000_0000, 32'd4);
        tick();                                                   // cycle 1
        tick();                                                   // cycle 2
        tick();                                                   // cycle 3
        bus.cp_wait = 2'b01;
        tick();                                                   // cycle 4
        chk("ab_busy", 32'(bus.core_wait), 32'd1);
        tick();                                                   // cycle 5
        bus.core_valid   = 1'b0;
        bus.cp_ready     = 2'b01;
        bus.cp_wr        = 2'b01;
        bus.cp_rd[31:0]  = 32'd2;
        tick();                                                   // cycle 6
        chk("ab_valid_clr", 32'(bus.cp_valid), 32'd0);
        chk("ab_no_ready", 32'(bus.core_ready), 32'd0);
        chk("ab_wait_low", 32'(bus.core_wait), 32'd0);
        drive_req(muldiv_insn(F3_MUL, 5'd7, 5'd1, 5'd2), 32'd3, 32'd3);
        tick();                                                   // cycle 7
        chk("ab_hold_off", 32'(bus.cp_valid), 32'd0);
        bus.cp_wait  = 2'b00;
        bus.cp_ready = 2'b00;
        tick();                                                   // cycle 8
        chk("ab_idle", 32'(bus.cp_valid), 32'd0);
        tick();                                                   // cycle 9
        chk("ab_reissue", 32'(bus.cp_valid), 32'd3);
        chk("ab_reissue_rs1", bus.cp_rs1, 32'd3);
        idle_inputs();
        tick();
        tick();
        tick();
        chk("ab_ready_count", 32'(ready_seen), 32'(ready_mark));

        // Single-cycle co-processor on port 1, ready at cycle 2, wr=0
        drive_req(32'h1234_5033, 32'h11, 32'h22);
        tick();                                                   // cycle 1
        tick();                                                   // cycle 2
        bus.cp_ready      = 2'b10;
        bus.cp_wr         = 2'b00;
        bus.cp_rd[63:32]  = 32'h0000_1234;
        exp_q.push_back('{wr: 1'b0, rd: 32'h0000_1234});
        chk("sc_wait_c2", 32'(bus.core_wait), 32'd0);
        tick();                                                   // cycle 3
        chk("sc_ready_c3", 32'(bus.core_ready), 32'd1);
        chk("sc_wait_c3", 32'(bus.core_wait), 32'd0);
        idle_inputs();
        tick();
        tick();
        chk("sc_rd_hold", bus.core_rd, 32'h0000_1234);

        // Asynchronous reset while BUSY
        drive_req(muldiv_insn(F3_MUL, 5'd3, 5'd1, 5'd2), 32'd9, 32'd9);
        tick();
        tick();
        tick();
        bus.cp_wait = 2'b01;
        tick();
        chk("rb_busy", 32'(bus.core_wait), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("rb_wait", 32'(bus.core_wait), 32'd0);
        chk("rb_cp_valid", 32'(bus.cp_valid), 32'd0);
        chk("rb_conflict", 32'(bus.cp_conflict), 32'd0);
        chk("rb_core_rd", bus.core_rd, 32'd0);
        chk("rb_cp_rs1", bus.cp_rs1, 32'd0);
        idle_inputs();
        tick();
        resetn = 1'b1;
        tick();

        // MUL 0xFFFFFFFF * 2 after reset
        drive_req(muldiv_insn(F3_MUL, 5'd3, 5'd1, 5'd2), 32'hFFFF_FFFF, 32'd2);
        tick();
        tick();
        tick();
        bus.cp_wait = 2'b01;
        tick();
        prod = 64'(bus.cp_rs1) * 64'(bus.cp_rs2);
        bus.cp_wait      = 2'b00;
        bus.cp_ready     = 2'b01;
        bus.cp_wr        = 2'b01;
        bus.cp_rd[31:0]  = prod[31:0];
        exp_q.push_back('{wr: 1'b1, rd: 32'hFFFF_FFFE});
        tick();
        chk("big_ready", 32'(bus.core_ready), 32'd1);
        idle_inputs();
        tick();
        tick();

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("ready_total", 32'(ready_seen), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
